ssram_arb2: RTL and testbench

- Two-requester arbiter and sequencer in front of one single-port, write-first synchronous RAM (1-cycle read latency, 10-bit address).
- Each requester uses a valid/ready request channel and a fixed-latency response strobe.
- Round-robin fairness, with an optional bounded lock for atomic read-modify-write sequences.
- Sits between the AHB-side SSRAM bridge (requester 0) and a DMA/debug port (requester 1).

---
 rtl/ssram_arb2_pkg.sv | 11 +
 rtl/ssram_arb2_if.sv | 29 ++
 rtl/ssram_arb2_rr.sv | 25 ++
 rtl/ssram_arb2.sv | 114 +++++++++++
 tb/tb_ssram_arb2.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ssram_arb2_pkg.sv
// Shared types for the two-requester SSRAM arbiter: FSM states, requester index
// and the default lock bound.
package ssram_arb_pkg;

   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

   typedef logic req_idx_t;

   localparam int LOCK_MAX_DEF = 8;

endpackage

// File: rtl/ssram_arb2_if.sv
// Request/response bundle for the two requesters of ssram_arb2.
// master = requester side, slave = arbiter side.
interface ssram_arb2_if #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
);

   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0]            req_we;
   logic [1:0]            req_lock;
   logic [ADDR_WIDTH-1:0] req_addr0;
   logic [ADDR_WIDTH-1:0] req_addr1;
   logic [WORD_WIDTH-1:0] req_wdata0;
   logic [WORD_WIDTH-1:0] req_wdata1;
   logic [1:0]            rsp_valid;
   logic [WORD_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/ssram_arb2_rr.sv
// Combinational two-way round-robin pick: one-hot grant from the eligible
// valids and rr pointer, plus the pointer value to adopt after a grant.
module rr_arb2
   import ssram_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  req_idx_t   rr_ptr_i,
   output logic [1:0] gnt_o,
   output req_idx_t   gnt_idx_o,
   output req_idx_t   rr_ptr_nxt_o
);

   always_comb begin
      gnt_idx_o = 1'b0;
      unique case (valid_i)
         2'b01:   gnt_idx_o = 1'b0;
         2'b10:   gnt_idx_o = 1'b1;
         2'b11:   gnt_idx_o = rr_ptr_i;
         default: gnt_idx_o = 1'b0;
      endcase
      gnt_o        = (valid_i == 2'b00) ? 2'b00 : (2'b01 << gnt_idx_o);
      rr_ptr_nxt_o = ~gnt_idx_o;
   end

endmodule

// File: rtl/ssram_arb2.sv
// Arbiter/sequencer for one write-first single-port sync RAM shared by two
// requesters: round-robin grant, bounded lock for RMW, fixed 1-cycle response.
module ssram_arb2
   import ssram_arb_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   ssram_arb2_if.slave           arb_s,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [WORD_WIDTH-1:0] ram_din_o,
   input  logic [WORD_WIDTH-1:0] ram_dout_i
);

   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

   state_e                state_q;
   req_idx_t              owner_q;
   req_idx_t              rr_ptr_q;
   logic [CW-1:0]         lock_cnt_q;
   logic [1:0]            rsp_valid_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0] din_q;

   logic [1:0]            elig;
   logic [1:0]            gnt;
   req_idx_t              g;
   req_idx_t              rr_nxt;
   logic                  acc;
   logic                  lock_bit;
   logic [CW-1:0]         lock_cnt_d;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WORD_WIDTH-1:0] sel_din;

   // Under lock only the owner is eligible; the other side waits.
   always_comb begin
      elig = arb_s.req_valid;
      if (state_q == LOCK) elig = arb_s.req_valid & (2'b01 << owner_q);
   end

   rr_arb2 u_rr (
      .valid_i      (elig),
      .rr_ptr_i     (rr_ptr_q),
      .gnt_o        (gnt),
      .gnt_idx_o    (g),
      .rr_ptr_nxt_o (rr_nxt)
   );

   assign arb_s.req_ready = rst ? 2'b00 : gnt;
   assign acc             = |arb_s.req_ready;
   assign lock_bit        = arb_s.req_lock[g];
   assign lock_cnt_d      = lock_cnt_q + 1'b1;
   assign sel_addr        = g ? arb_s.req_addr1  : arb_s.req_addr0;
   assign sel_din         = g ? arb_s.req_wdata1 : arb_s.req_wdata0;

   // Address/data hold their last granted value while idle.
   assign ram_en_o   = acc;
   assign ram_we_o   = acc & arb_s.req_we[g];
   assign ram_addr_o = acc ? sel_addr : addr_q;
   assign ram_din_o  = acc ? sel_din  : din_q;

   assign arb_s.rsp_valid = rsp_valid_q;
   assign arb_s.rsp_rdata = ram_dout_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB;
         owner_q     <= 1'b0;
         rr_ptr_q    <= 1'b0;
         lock_cnt_q  <= '0;
         rsp_valid_q <= 2'b00;
         addr_q      <= '0;
         din_q       <= '0;
      end else begin
         rsp_valid_q <= arb_s.req_ready;
         if (acc) begin
            addr_q <= sel_addr;
            din_q  <= sel_din;
         end
         unique case (state_q)
            ARB: begin
               if (acc) begin
                  rr_ptr_q <= rr_nxt;
                  if (lock_bit && (LOCK_MAX > 1)) begin
                     state_q    <= LOCK;
                     owner_q    <= g;
                     lock_cnt_q <= CW'(1);
                  end
               end
            end
            LOCK: begin
               if (acc) begin
                  // Release on an unlocked transfer or when the bound is reached.
                  if (!lock_bit || (lock_cnt_d == LOCK_MAX_C)) begin
                     state_q    <= ARB;
                     rr_ptr_q   <= ~owner_q;
                     lock_cnt_q <= '0;
                  end else begin
                     lock_cnt_q <= lock_cnt_d;
                  end
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_ssram_arb2.sv
// Directed + random bench for ssram_arb2 with a write-first RAM and a
// transaction-level reference model of grant order, locking and responses.
module tb_ssram_arb2;
   import ssram_arb_pkg::*;

   localparam int WW = 16;
   localparam int AW = 10;
   localparam int LM = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ssram_arb2_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [WW-1:0] ram_din, ram_dout;

   ssram_arb2 #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
      .clk        (clk),
      .rst        (rst),
      .arb_s      (bus),
      .ram_en_o   (ram_en),
      .ram_we_o   (ram_we),
      .ram_addr_o (ram_addr),
      .ram_din_o  (ram_din),
      .ram_dout_i (ram_dout)
   );

   // Write-first single-port RAM outside the block.
   logic [WW-1:0] ram_mem [1024];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
            ram_dout          <= ram_din;
         end else begin
            ram_dout <= ram_mem[ram_addr];
         end
      end
   end

   // Reference model state
   logic [WW-1:0] ref_mem [1024];
   int            m_rr;
   int            m_owner;
   int            m_cnt;
   logic [AW-1:0] m_last_a;
   logic [WW-1:0] m_last_d;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [WW-1:0] d0, input logic [WW-1:0] d1);
      bus.req_valid  = v;
      bus.req_we     = we;
      bus.req_lock   = lk;
      bus.req_addr0  = a0;
      bus.req_addr1  = a1;
      bus.req_wdata0 = d0;
      bus.req_wdata1 = d1;
   endtask

   task automatic model_reset();
      m_rr     = 0;
      m_owner  = -1;
      m_cnt    = 0;
      m_last_a = '0;
      m_last_d = '0;
   endtask

   // One clock: inputs already applied at the negedge. Check request-side
   // outputs, update the model, then check the response after the edge.
   task automatic cycle();
      int            g;
      logic [1:0]    er;
      logic [1:0]    ersp;
      logic [WW-1:0] erd;
      logic [AW-1:0] a;
      logic [WW-1:0] d;
      #1;
      g = -1;
      if (m_owner >= 0) begin
         if (bus.req_valid[m_owner]) g = m_owner;
      end else if (bus.req_valid == 2'b11) g = m_rr;
      else if (bus.req_valid[0]) g = 0;
      else if (bus.req_valid[1]) g = 1;
      er = 2'b00;
      if (g == 0) er = 2'b01;
      if (g == 1) er = 2'b10;
      ersp = er;
      erd  = '0;
      if (g >= 0) begin
         a = (g == 1) ? bus.req_addr1  : bus.req_addr0;
         d = (g == 1) ? bus.req_wdata1 : bus.req_wdata0;
         m_last_a = a;
         m_last_d = d;
      end
      chk("ready",    {30'd0, bus.req_ready}, {30'd0, er});
      chk("ram_en",   {31'd0, ram_en}, {31'd0, (g >= 0)});
      chk("ram_we",   {31'd0, ram_we}, {31'd0, (g >= 0) && bus.req_we[g]});
      chk("ram_addr", {22'd0, ram_addr}, {22'd0, m_last_a});
      chk("ram_din",  {16'd0, ram_din},  {16'd0, m_last_d});
      if (g >= 0) begin
         if (bus.req_we[g]) begin
            ref_mem[m_last_a] = m_last_d;
            erd = m_last_d;
         end else begin
            erd = ref_mem[m_last_a];
         end
         if (m_owner < 0) begin
            m_rr = 1 - g;
            if (bus.req_lock[g] && LM > 1) begin
               m_owner = g;
               m_cnt   = 1;
            end
         end else begin
            m_cnt++;
            if (!bus.req_lock[g] || m_cnt == LM) begin
               m_owner = -1;
               m_cnt   = 0;
               m_rr    = 1 - g;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, ersp});
      if (ersp != 2'b00) chk("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, erd});
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = WW'(i * 7);
         ref_mem[i] = WW'(i * 7);
      end
      ram_mem[5] = 16'hBEEF;
      ref_mem[5] = 16'hBEEF;
      model_reset();

      // Reset: outputs quiet even with both requesters valid.
      rst = 1'b1;
      drive(2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready",  {30'd0, bus.req_ready}, 32'd0);
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_rsp",    {30'd0, bus.rsp_valid}, 32'd0);
      rst = 1'b0;
      drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      cycle();

      // Single read of preloaded word.
      drive(2'b01, 2'b00, 2'b00, 10'h005, '0, '0, '0);
      cycle();
      drive(2'b00, 2'b00, 2'b00, 10'h005, '0, '0, '0);
      cycle();

      // Rotate pointer back to req0, then contention: req0 writes, req1 reads.
      drive(2'b10, 2'b00, 2'b00, '0, 10'h005, '0, '0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b01, 2'b00, AW'(10'h020 + i), 10'h020, WW'(16'hA000 + i), '0);
         cycle();
      end

      // Write-first: req1 writes 0x3FF then req0 reads it back.
      drive(2'b10, 2'b10, 2'b00, '0, 10'h3FF, '0, 16'h1234);
      cycle();
      drive(2'b01, 2'b00, 2'b00, 10'h3FF, '0, '0, '0);
      cycle();
      drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      cycle();

      // Lock release: pointer to req0 first, 3 locked + 1 unlocked, req1 waits.
      drive(2'b10, 2'b00, 2'b00, '0, 10'h001, '0, '0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 2'b01, 2'b01, AW'(10'h040 + i), 10'h3FF, WW'(16'h5500 + i), '0);
         cycle();
      end
      drive(2'b11, 2'b00, 2'b00, 10'h040, 10'h3FF, '0, '0);
      cycle();
      drive(2'b11, 2'b00, 2'b00, 10'h041, 10'h005, '0, '0);
      cycle();

      // Forced release after LM locked transfers.
      for (int i = 0; i < 14; i++) begin
         drive(2'b11, 2'b01, 2'b01, AW'(10'h080 + i), 10'h040, WW'(16'h7700 + i), '0);
         cycle();
      end
      drive(2'b11, 2'b00, 2'b00, 10'h080, 10'h081, '0, '0);
      cycle();
      drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      cycle();

      // Reset mid-op: response pending is dropped; req0 wins after release.
      drive(2'b01, 2'b00, 2'b01, 10'h005, '0, '0, '0);
      cycle();
      rst = 1'b1;
      #1;
      chk("midrst_rsp",   {30'd0, bus.rsp_valid}, 32'd0);
      chk("midrst_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("midrst_en",    {31'd0, ram_en}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(2'b11, 2'b00, 2'b00, 10'h005, 10'h3FF, '0, '0);
      cycle();
      cycle();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive(2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom),
               AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
               WW'($urandom), WW'($urandom));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
